// File: rtl/alu_share_arbiter_if.sv
// Opcode type and requester-side handshake bundle for the shared-ALU arbiter.
`ifndef ALU_SHARE_ARBITER_IF_SV
`define ALU_SHARE_ARBITER_IF_SV

package alu_share_pkg;
  // Encoding 0 is ALU_A so a cleared opcode register selects pass-through of A.
  typedef enum logic [3:0] {
    ALU_A   = 4'd0,
    ALU_B   = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_XOR = 4'd6,
    ALU_SLT = 4'd7
  } alu_control_t;
endpackage

interface alu_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32
);
  import alu_share_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_b;
  alu_control_t                   req_ctrl [NUM_REQ];
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [NUM_REQ-1:0]             rsp_ready;
  logic [DATA_W-1:0]              rsp_data;

  // Requester side.
  modport master (
    output req_valid, req_a, req_b, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

`endif

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Accept (IDLE) -> one ALU cycle (EXEC) -> hold response until owner acks (RESP).
`include "alu_share_arbiter_if.sv"

module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  alu_share_arbiter_if.slave  bus,
  output logic [DATA_W-1:0]   alu_a_o,
  output logic [DATA_W-1:0]   alu_b_o,
  output alu_control_t        alu_control_o,
  input  logic [DATA_W-1:0]   alu_result_i,
  output logic [ID_W-1:0]     grant_id_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   grant_q;
  logic [DATA_W-1:0] a_q, b_q, result_q;
  alu_control_t      ctrl_q;

  logic              found;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand;
  logic              accept;
  logic              rsp_fire;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign accept   = (state_q == StIdle) && found;
  // Only the owner's ready bit can complete the response.
  assign rsp_fire = (state_q == StResp) && bus.rsp_ready[grant_q];

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: handshakes decoded from state, datapath straight from registers.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (accept) begin
      bus.req_ready[winner] = 1'b1;
    end
    if (state_q == StResp) begin
      bus.rsp_valid[grant_q] = 1'b1;
    end
    bus.rsp_data  = result_q;
    busy_o        = (state_q != StIdle);
    alu_a_o       = a_q;
    alu_b_o       = b_q;
    alu_control_o = ctrl_q;
    grant_id_o    = grant_q;
  end

  // Operand capture on accept, result capture and pointer advance in EXEC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= ALU_A;
      result_q <= '0;
    end else begin
      if (accept) begin
        a_q     <= bus.req_a[winner];
        b_q     <= bus.req_b[winner];
        ctrl_q  <= bus.req_ctrl[winner];
        grant_q <= winner;
      end
      if (state_q == StExec) begin
        result_q <= alu_result_i;
        rr_ptr_q <= (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table of single operations plus
// hand-written arbitration, back-pressure, wrap-around and reset sequences.
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 32;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  alu_control_t      alu_control;
  logic [1:0]        grant_id;
  logic              busy;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  alu_share_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_control_o(alu_control),
    .alu_result_i (alu_result),
    .grant_id_o   (grant_id),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU standing in for the shared instance.
  always_comb begin
    case (alu_control)
      ALU_A:   alu_result = alu_a;
      ALU_B:   alu_result = alu_b;
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_XOR: alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    int unsigned  r;
    logic [31:0]  a;
    logic [31:0]  b;
    alu_control_t op;
    logic [31:0]  exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int unsigned r);
    logic [3:0] one;
    one = 4'b0001;
    return one << r;
  endfunction

  // Advance one clock; leaves time just after the edge for driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned r, input logic [31:0] a, input logic [31:0] b,
                       input alu_control_t op);
    bus.req_valid[r] = 1'b1;
    bus.req_a[r]     = a;
    bus.req_b[r]     = b;
    bus.req_ctrl[r]  = op;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    step();
    step();
    check("rst_req_ready", 64'(bus.req_ready), 64'h0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_rsp_data", 64'(bus.rsp_data), 64'h0);
    check("rst_grant", 64'(grant_id), 64'h0);
    check("rst_alu_ctrl", 64'(alu_control), 64'(ALU_A));
    rst = 1'b0;
  endtask

  // One isolated operation with full timing checks.
  task automatic run_op(input vec_t v);
    bus.req_valid = '0;
    drive(v.r, v.a, v.b, v.op);
    #1;
    check("vec_accept_ready", 64'(bus.req_ready), 64'(oh(v.r)));
    check("vec_idle_busy", 64'(busy), 64'h0);
    step();
    bus.req_valid[v.r] = 1'b0;
    #1;
    check("vec_exec_busy", 64'(busy), 64'h1);
    check("vec_exec_ready", 64'(bus.req_ready), 64'h0);
    check("vec_exec_alu_a", 64'(alu_a), 64'(v.a));
    check("vec_exec_alu_ctrl", 64'(alu_control), 64'(v.op));
    step();
    check("vec_rsp_valid", 64'(bus.rsp_valid), 64'(oh(v.r)));
    check("vec_rsp_data", 64'(bus.rsp_data), 64'(v.exp));
    check("vec_grant", 64'(grant_id), 64'(v.r));
    bus.rsp_ready[v.r] = 1'b1;
    step();
    bus.rsp_ready = '0;
    #1;
    check("vec_done_valid", 64'(bus.rsp_valid), 64'h0);
    check("vec_done_busy", 64'(busy), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{r: 2, a: 32'd5,         b: 32'd7,         op: ALU_ADD, exp: 32'd12};
    vecs[1] = '{r: 1, a: 32'd3,         b: 32'd5,         op: ALU_SUB, exp: 32'hFFFF_FFFE};
    vecs[2] = '{r: 0, a: 32'h0000_F0F0, b: 32'h0000_0FF0, op: ALU_AND, exp: 32'h0000_00F0};
    vecs[3] = '{r: 3, a: 32'hFFFF_FFFF, b: 32'd1,         op: ALU_ADD, exp: 32'h0};
    vecs[4] = '{r: 0, a: 32'hA,         b: 32'h5,         op: ALU_OR,  exp: 32'hF};
    vecs[5] = '{r: 2, a: 32'h1234,      b: 32'hFF,        op: ALU_A,   exp: 32'h1234};
    vecs[6] = '{r: 1, a: 32'h1234,      b: 32'hFF,        op: ALU_B,   exp: 32'hFF};
    vecs[7] = '{r: 3, a: 32'hFF00,      b: 32'h0FF0,      op: ALU_XOR, exp: 32'hF0F0};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) bus.req_ctrl[i] = ALU_A;

    do_reset();
    foreach (vecs[i]) run_op(vecs[i]);

    // All four valid continuously: grants 0,1,2,3,0, three cycles each.
    do_reset();
    for (int unsigned r = 0; r < NUM_REQ; r++) drive(r, 32'(r), 32'd10, ALU_ADD);
    bus.rsp_ready = '1;
    for (int unsigned k = 0; k < 5; k++) begin
      #1;
      check("rr_ready", 64'(bus.req_ready), 64'(oh(k % 4)));
      step();
      step();
      check("rr_rsp_valid", 64'(bus.rsp_valid), 64'(oh(k % 4)));
      check("rr_rsp_data", 64'(bus.rsp_data), 64'((k % 4) + 10));
      step();
    end
    bus.req_valid = '0;
    bus.rsp_ready = '0;

    // Back-pressure on requester 1 while requester 3 waits.
    do_reset();
    drive(1, 32'd3, 32'd5, ALU_SUB);
    drive(3, 32'd9, 32'd1, ALU_ADD);
    #1;
    check("bp_accept", 64'(bus.req_ready), 64'h2);
    step();
    bus.req_valid[1] = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", 64'(bus.rsp_valid), 64'h2);
      check("bp_hold_data", 64'(bus.rsp_data), 64'hFFFF_FFFE);
      check("bp_hold_noready", 64'(bus.req_ready), 64'h0);
      step();
    end
    bus.rsp_ready[1] = 1'b1;
    step();
    bus.rsp_ready = '0;
    #1;
    check("bp_next_accept", 64'(bus.req_ready), 64'h8);
    step();
    bus.req_valid[3] = 1'b0;
    step();
    check("bp_r3_data", 64'(bus.rsp_data), 64'd10);
    bus.rsp_ready[3] = 1'b1;
    step();
    bus.rsp_ready = '0;

    // Wrap-around: serve 2 so rr_ptr=3, then 0 and 3 compete.
    run_op(vecs[0]);
    drive(0, 32'd1, 32'd1, ALU_ADD);
    drive(3, 32'd2, 32'd2, ALU_ADD);
    #1;
    check("wrap_first", 64'(bus.req_ready), 64'h8);
    step();
    bus.req_valid[3] = 1'b0;
    step();
    bus.rsp_ready[3] = 1'b1;
    step();
    bus.rsp_ready = '0;
    drive(1, 32'd4, 32'd4, ALU_ADD);
    #1;
    check("wrap_ptr0", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid[0] = 1'b0;
    step();
    // Wrong-owner ack must not release requester 0's response.
    bus.rsp_ready = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("wo_valid", 64'(bus.rsp_valid), 64'h1);
      check("wo_busy", 64'(busy), 64'h1);
      step();
    end
    check("wo_still_valid", 64'(bus.rsp_valid), 64'h1);
    bus.rsp_ready = 4'b0001;
    step();
    bus.rsp_ready = '0;
    #1;
    check("wrap_ptr1", 64'(bus.req_ready), 64'h2);
    step();
    bus.req_valid[1] = 1'b0;
    step();
    bus.rsp_ready[1] = 1'b1;
    step();
    bus.rsp_ready = '0;

    // Reset in EXEC: rr_ptr is 2 here, so requester 2 would win without the reset.
    drive(2, 32'd6, 32'd6, ALU_SUB);
    #1;
    check("rx_accept", 64'(bus.req_ready), 64'h4);
    step();
    bus.req_valid[2] = 1'b0;
    #1;
    check("rx_in_exec", 64'(busy), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rx_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("rx_busy", 64'(busy), 64'h0);
    check("rx_alu_ctrl", 64'(alu_control), 64'(ALU_A));
    check("rx_grant", 64'(grant_id), 64'h0);
    step();
    check("rx_no_rsp", 64'(bus.rsp_valid), 64'h0);
    drive(0, 32'd8, 32'd1, ALU_SUB);
    drive(2, 32'd8, 32'd2, ALU_SUB);
    #1;
    check("rx_ptr_reset", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid = '0;
    step();
    check("rx_r0_data", 64'(bus.rsp_data), 64'd7);
    bus.rsp_ready[0] = 1'b1;
    step();
    bus.rsp_ready = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between NUM_REQ requesters, e.g. GPU shader lanes or the address-generation unit.
- Each requester issues an operation (operand A, operand B, alu_control_t opcode) over a valid/ready handshake.
- A round-robin arbiter grants one requester at a time. The block latches the operands, drives the shared ALU, registers the result and returns it to the granted requester over a valid/ready response handshake.
- Sits between the requesters and the ALU instance in the processor datapath.

Parameters:
- NUM_REQ, 4, number of requesters; must be at least 2.
- DATA_W, 32, operand and result width.
- ID_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester request accepted this cycle (one-hot or zero).
- req_a_i  in  NUM_REQ x DATA_W  operand A per requester.
- req_b_i  in  NUM_REQ x DATA_W  operand B per requester.
- req_ctrl_i  in  NUM_REQ x alu_control_t  opcode per requester.
- alu_a_o  out  DATA_W  operand A to the shared ALU.
- alu_b_o  out  DATA_W  operand B to the shared ALU.
- alu_control_o  out  alu_control_t  opcode to the shared ALU.
- alu_result_i  in  DATA_W  combinational ALU result.
- rsp_valid_o  out  NUM_REQ  per-requester response valid (one-hot or zero).
- rsp_ready_i  in  NUM_REQ  per-requester response ready.
- rsp_data_o  out  DATA_W  result, shared by all requesters; meaningful only for the requester whose rsp_valid_o bit is set.
- grant_id_o  out  ID_W  index of the current owner.
- busy_o  out  1  high in EXEC and RESP.

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset: state IDLE, rr_ptr 0, grant 0, operand registers 0, opcode register ALU_A, result register 0.
  - All of req_ready_o, rsp_valid_o and busy_o are 0; rsp_data_o is 0; grant_id_o is 0.
  - Reset mid-operation discards the in-flight operation with no response.
- IDLE:
  - Winner = first index i with req_valid_i[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready_o[winner]=1 combinationally in the same cycle; all other req_ready_o bits are 0.
  - On that edge: latch req_a/b/ctrl[winner] into the operand registers, set grant=winner, go to EXEC.
  - No valid request: stay in IDLE with req_ready_o all 0.
- EXEC (exactly 1 cycle):
  - alu_a_o, alu_b_o and alu_control_o come straight from the operand registers, which are stable in every state.
  - Capture alu_result_i into the result register.
  - rr_ptr <= (grant+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
  - Go to RESP.
  - req_ready_o is all 0.
- RESP:
  - rsp_valid_o[grant]=1 and rsp_data_o = result register.
  - Hold until rsp_ready_i[grant]=1, then go to IDLE.
  - rsp_ready_i bits of non-owners are ignored.
  - req_ready_o is all 0, so no new accept happens in the same cycle as the response handshake.
- Latency: request accept at edge N, response valid from cycle N+2. Minimum 3 cycles per operation.
- Requests must hold valid, operands and opcode until accepted; the block samples them only in the accept cycle.
- A request whose valid drops before it is granted is not served.
- grant_id_o = grant register.
- Fairness: a continuously asserted request is served within NUM_REQ grants.
- The block performs no arithmetic itself; results are the ALU's DATA_W bits unmodified.

Test Plan:
- Reset, then single request: requester 2 sends A=5, B=7, ALU_ADD -> req_ready_o=4'b0100 in the accept cycle; two cycles later rsp_valid_o=4'b0100 and rsp_data_o=12.
- All four requesters valid continuously after reset -> grants in order 0,1,2,3,0. Each response is acked immediately and each operation takes 3 cycles.
- Back-pressure: requester 1 does ALU_SUB with A=3, B=5 and holds rsp_ready_i low for 5 cycles -> rsp_valid_o[1] and rsp_data_o=32'hFFFF_FFFE are held stable for all 5 cycles. Requester 3, valid throughout, gets no req_ready_o until requester 1 acks.
- Wrap-around: rr_ptr=3, requesters 0 and 3 valid -> 3 is granted first, then 0, and rr_ptr becomes 0 then 1.
- Wrong-owner ack: rsp_ready_i=4'b1000 while requester 0 owns the response -> stays in RESP with rsp_valid_o=4'b0001 until rsp_ready_i[0]=1.
- Reset asserted during EXEC -> next cycle state is IDLE, rsp_valid_o=0, busy_o=0, alu_control_o=ALU_A, and rr_ptr=0 so requester 0 wins the next grant.
